// File: rtl/code_lock_fsm_if.sv
// Button/LED bundle for the combination lock.
// master drives the debounced press pulses; slave (the lock) drives status.
interface code_lock_fsm_if;
    logic [3:0] btn;
    logic       unlocked;
    logic       alarm;
    logic [2:0] digits_entered;
    logic [1:0] fail_count;
    logic [1:0] state;

    modport master (
        output btn,
        input  unlocked, alarm, digits_entered, fail_count, state
    );

    modport slave (
        input  btn,
        output unlocked, alarm, digits_entered, fail_count, state
    );
endinterface

// File: rtl/code_lock_fsm.sv
// 4-digit combination lock driven by one-pulse button presses.
// Presses arrive from a slow debounce domain, so each button bit is
// synchronized and rising-edge detected before the FSM sees it.
module code_lock_fsm #(
    parameter logic [7:0]  CODE           = 8'h1B,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned UNLOCK_CYCLES  = 300000000,
    parameter int unsigned LOCKOUT_CYCLES = 1000000000,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic           clk_in,
    input  logic           rst,
    code_lock_fsm_if.slave bus
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ENTRY    = 2'd1;
    localparam logic [1:0] S_UNLOCKED = 2'd2;
    localparam logic [1:0] S_LOCKOUT  = 2'd3;

    localparam int unsigned MAX_AB  = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
    localparam int          TW      = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] UNL_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);

    logic [3:0]    sync1, sync2, dly, ev;
    logic [1:0]    state_q;
    logic [1:0]    de_q;
    logic [1:0]    fc_q;
    logic          mis_q;
    logic [TW-1:0] timer_q;

    logic          press, multi, hit;
    logic [1:0]    digit, exp_digit;
    logic [2:0]    fc_inc;
    logic [7:0]    code_v;

    // 2-FF synchronizer, delay stage and registered one-cycle rise event per button
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            dly   <= '0;
            ev    <= '0;
        end else begin
            sync1 <= bus.btn;
            sync2 <= sync1;
            dly   <= sync2;
            ev    <= sync2 & ~dly;
        end
    end

    // Decode the press: digit index, multi-button flag, and match against the expected digit
    always_comb begin
        digit = 2'd0;
        for (int j = 0; j < 4; j++)
            if (ev[j]) digit = 2'(j);
        code_v    = CODE;
        press     = |ev;
        multi     = |(ev & (ev - 4'd1));
        exp_digit = code_v[{de_q, 1'b0} +: 2];
        hit       = press & ~multi & (digit == exp_digit);
        fc_inc    = {1'b0, fc_q} + 3'd1;
    end

    // Lock state machine; one shared timer restarts on every state entry and accepted digit
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            de_q    <= '0;
            fc_q    <= '0;
            mis_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (press) begin
                        state_q <= S_ENTRY;
                        de_q    <= 2'd1;
                        mis_q   <= ~hit;
                    end
                end
                S_ENTRY: begin
                    if (press) begin
                        // a press beats a coincident timeout
                        timer_q <= '0;
                        if (de_q == 2'd3) begin
                            de_q <= '0;
                            if (!(mis_q | ~hit)) begin
                                state_q <= S_UNLOCKED;
                                fc_q    <= '0;
                            end else if (fc_inc >= 3'(MAX_FAIL)) begin
                                state_q <= S_LOCKOUT;
                                fc_q    <= 2'(MAX_FAIL);
                            end else begin
                                state_q <= S_IDLE;
                                fc_q    <= fc_inc[1:0];
                            end
                        end else begin
                            de_q  <= de_q + 2'd1;
                            mis_q <= mis_q | ~hit;
                        end
                    end else if (timer_q == TO_LAST) begin
                        // abandoned attempt: not counted as a failure
                        state_q <= S_IDLE;
                        de_q    <= '0;
                        timer_q <= '0;
                    end
                end
                S_UNLOCKED: begin
                    // any press relocks and is otherwise discarded
                    if (press || timer_q == UNL_LAST) begin
                        state_q <= S_IDLE;
                        timer_q <= '0;
                    end
                end
                default: begin
                    if (timer_q == LOCK_LAST) begin
                        state_q <= S_IDLE;
                        fc_q    <= '0;
                        timer_q <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.state          = state_q;
    assign bus.unlocked       = (state_q == S_UNLOCKED);
    assign bus.alarm          = (state_q == S_LOCKOUT);
    assign bus.digits_entered = {1'b0, de_q};
    assign bus.fail_count     = fc_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scenario bench for code_lock_fsm with shortened timers.
// Expected snapshots are queued when a press is driven and popped when the
// lock has had time to react (4 clk_in edges after the button rises).
module tb_code_lock_fsm;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] de;
        logic [1:0] fc;
        logic       unl;
        logic       alm;
    } obs_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    obs_t sb[$];

    code_lock_fsm_if bi();

    code_lock_fsm #(
        .CODE(8'h1B), .TIMEOUT_CYCLES(20), .UNLOCK_CYCLES(10),
        .LOCKOUT_CYCLES(30), .MAX_FAIL(3)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bi)
    );

    always #5 clk_in = ~clk_in;

    function automatic obs_t mk(input int st, input int de, input int fc);
        obs_t r;
        r.st  = 2'(st);
        r.de  = 3'(de);
        r.fc  = 2'(fc);
        r.unl = (st == 2);
        r.alm = (st == 3);
        return r;
    endfunction

    function automatic obs_t snap();
        obs_t r;
        r.st  = bi.state;
        r.de  = bi.digits_entered;
        r.fc  = bi.fail_count;
        r.unl = bi.unlocked;
        r.alm = bi.alarm;
        return r;
    endfunction

    function automatic string fmt(input obs_t v);
        return $sformatf("st=%0d de=%0d fc=%0d unl=%0b alm=%0b", v.st, v.de, v.fc, v.unl, v.alm);
    endfunction

    // Raise m, sample 4 edges later, hold, release, then idle gap cycles.
    task automatic press(input logic [3:0] m, input int hold, input int gap, output obs_t o);
        @(negedge clk_in); bi.btn = m;
        repeat (4) @(posedge clk_in);
        #1 o = snap();
        repeat (hold - 4) @(posedge clk_in);
        @(negedge clk_in); bi.btn = '0;
        repeat (gap) @(negedge clk_in);
    endtask

    task automatic test_reset;
        obs_t o, e;
        bi.btn = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk_in);
        sb.push_back(mk(0, 0, 0));
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_held: got %s want %s", fmt(o), fmt(e)); end
        @(negedge clk_in) rst = 1'b0;
        sb.push_back(mk(0, 0, 0));
        repeat (3) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_release: got %s want %s", fmt(o), fmt(e)); end
    endtask

    // Correct code 3,2,1,0 from fail_count=0; measures the unlock window.
    task automatic test_correct;
        logic [3:0] ms[3] = '{4'b1000, 4'b0100, 4'b0010};
        obs_t o, e;
        int cnt;
        for (int i = 0; i < 3; i++) sb.push_back(mk(1, i + 1, 0));
        for (int i = 0; i < 3; i++) begin
            press(ms[i], 8, 8, o);
            e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL correct_press%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        sb.push_back(mk(2, 0, 0));
        @(negedge clk_in); bi.btn = 4'b0001;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL correct_unlock: got %s want %s", fmt(o), fmt(e)); end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            if (bi.unlocked) cnt++; else break;
        end
        n_cmp++;
        if (cnt != 10) begin n_bad++; $display("FAIL unlock_window: got %0d cycles want 10", cnt); end
        sb.push_back(mk(0, 0, 0));
        o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL unlock_expire: got %s want %s", fmt(o), fmt(e)); end
        @(negedge clk_in); bi.btn = '0;
        repeat (6) @(negedge clk_in);
    endtask

    // Three wrong attempts (3,2,0,0) lead to lockout; presses inside lockout are ignored.
    task automatic test_wrong_lockout;
        logic [3:0] ms[4] = '{4'b1000, 4'b0100, 4'b0001, 4'b0001};
        obs_t o, e;
        int cnt, bad;
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < 3; i++) sb.push_back(mk(1, i + 1, a));
            if (a < 2) sb.push_back(mk(0, 0, a + 1));
            for (int i = 0; i < ((a < 2) ? 4 : 3); i++) begin
                press(ms[i], 8, 8, o);
                e = sb.pop_front(); n_cmp++;
                if (o !== e) begin n_bad++; $display("FAIL wrong_a%0d_p%0d: got %s want %s", a, i, fmt(o), fmt(e)); end
            end
        end
        sb.push_back(mk(3, 0, 3));
        @(negedge clk_in); bi.btn = 4'b0001;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lockout_enter: got %s want %s", fmt(o), fmt(e)); end
        bi.btn = '0;
        cnt = 1; bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_in); #1;
            if (i == 2)  bi.btn = 4'b1000;
            if (i == 12) bi.btn = '0;
            if (bi.digits_entered != 3'd0) bad++;
            if (bi.alarm) cnt++; else break;
        end
        bi.btn = '0;
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL lockout_ignore: got %0d cycles with digits_entered!=0 want 0", bad); end
        n_cmp++;
        if (cnt != 30) begin n_bad++; $display("FAIL lockout_window: got %0d cycles want 30", cnt); end
        sb.push_back(mk(0, 0, 0));
        o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL lockout_expire: got %s want %s", fmt(o), fmt(e)); end
        repeat (4) @(negedge clk_in);
    endtask

    task automatic test_lockout_recovery;
        test_correct();
    endtask

    // Simultaneous buttons count as a wrong digit; a long hold yields one event.
    task automatic test_invalid;
        logic [3:0] ms[4] = '{4'b1100, 4'b0100, 4'b0010, 4'b0001};
        obs_t o, e;
        for (int i = 0; i < 3; i++) sb.push_back(mk(1, i + 1, 0));
        sb.push_back(mk(0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            press(ms[i], 8, 8, o);
            e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL invalid_p%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        sb.push_back(mk(1, 1, 1));
        sb.push_back(mk(0, 0, 1));
        @(negedge clk_in); bi.btn = 4'b1000;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL hold_first: got %s want %s", fmt(o), fmt(e)); end
        repeat (96) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL hold_single_event: got %s want %s", fmt(o), fmt(e)); end
        bi.btn = '0;
        repeat (4) @(negedge clk_in);
    endtask

    // Entry abandons after 20 idle cycles; a press landing on that cycle keeps ENTRY.
    task automatic test_timeout;
        obs_t o, e;
        int k;
        sb.push_back(mk(1, 1, 1));
        @(negedge clk_in); bi.btn = 4'b1000;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL timeout_start: got %s want %s", fmt(o), fmt(e)); end
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            k++;
            if (i == 7) bi.btn = '0;
            if (bi.state == 2'd0) break;
        end
        n_cmp++;
        if (k != 20) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 20", k); end
        sb.push_back(mk(0, 0, 1));
        o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL timeout_abandon: got %s want %s", fmt(o), fmt(e)); end
        repeat (3) @(negedge clk_in);
        sb.push_back(mk(1, 1, 1));
        sb.push_back(mk(1, 2, 1));
        @(negedge clk_in); bi.btn = 4'b1000;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL edge_start: got %s want %s", fmt(o), fmt(e)); end
        repeat (8) @(posedge clk_in);
        #1 bi.btn = '0;
        repeat (8) @(posedge clk_in);
        #1 bi.btn = 4'b0100;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL press_at_timeout: got %s want %s", fmt(o), fmt(e)); end
        bi.btn = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in); #1;
            if (bi.state == 2'd0) break;
        end
        sb.push_back(mk(0, 0, 1));
        o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL edge_cleanup: got %s want %s", fmt(o), fmt(e)); end
        repeat (3) @(negedge clk_in);
    endtask

    // Press during UNLOCKED relocks and is discarded; rst mid-ENTRY clears everything.
    task automatic test_relock_reset;
        logic [3:0] ms[4] = '{4'b1000, 4'b0100, 4'b0001, 4'b0001};
        logic [3:0] okm[3] = '{4'b1000, 4'b0100, 4'b0010};
        obs_t o, e;
        for (int i = 0; i < 3; i++) sb.push_back(mk(1, i + 1, 1));
        for (int i = 0; i < 3; i++) begin
            press(okm[i], 8, 8, o);
            e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL relock_p%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        sb.push_back(mk(2, 0, 0));
        sb.push_back(mk(0, 0, 0));
        sb.push_back(mk(0, 0, 0));
        @(negedge clk_in); bi.btn = 4'b0001;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL relock_unlock: got %s want %s", fmt(o), fmt(e)); end
        @(negedge clk_in); bi.btn = '0;
        @(negedge clk_in); bi.btn = 4'b0010;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL relock_press: got %s want %s", fmt(o), fmt(e)); end
        repeat (5) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL relock_discard: got %s want %s", fmt(o), fmt(e)); end
        bi.btn = '0;
        repeat (4) @(negedge clk_in);
        // one wrong attempt so reset has a nonzero fail_count to clear
        for (int i = 0; i < 3; i++) sb.push_back(mk(1, i + 1, 0));
        sb.push_back(mk(0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            press(ms[i], 8, 8, o);
            e = sb.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL prereset_p%0d: got %s want %s", i, fmt(o), fmt(e)); end
        end
        sb.push_back(mk(1, 1, 1));
        sb.push_back(mk(0, 0, 0));
        sb.push_back(mk(1, 1, 0));
        sb.push_back(mk(1, 1, 0));
        @(negedge clk_in); bi.btn = 4'b1000;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_entry: got %s want %s", fmt(o), fmt(e)); end
        #2 rst = 1'b1;
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_async: got %s want %s", fmt(o), fmt(e)); end
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_held_btn: got %s want %s", fmt(o), fmt(e)); end
        repeat (6) @(posedge clk_in);
        #1 o = snap(); e = sb.pop_front(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_one_event: got %s want %s", fmt(o), fmt(e)); end
        bi.btn = '0;
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_correct();
        test_wrong_lockout();
        test_lockout_recovery();
        test_invalid();
        test_timeout();
        test_relock_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
Consumes the single-press pulses produced by the button debounce/one-pulse stage, one per button, and runs a 4-digit combination lock. Outputs an unlock strobe window and an alarm/lockout indication for the board LEDs. Input pulses are level-high for one slow-clock period, i.e. many clk_in cycles. The block therefore synchronizes them and rising-edge detects them in the clk_in domain.

Parameters:
CODE, 8'h1B, expected sequence; digit i = CODE[2i+1:2i], entered first-to-last as i=0..3 (default sequence 3,2,1,0)
TIMEOUT_CYCLES, 500000000, max clk_in cycles allowed between presses in ENTRY (5 s at 100 MHz)
UNLOCK_CYCLES, 300000000, duration of UNLOCKED state
LOCKOUT_CYCLES, 1000000000, duration of LOCKOUT state
MAX_FAIL, 3, consecutive failed codes that trigger LOCKOUT (range 1..3)

Ports:
clk_in  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn  input  4  debounced press pulses; btn[j] = digit j
unlocked  output  1  high while in UNLOCKED
alarm  output  1  high while in LOCKOUT
digits_entered  output  3  presses accepted in current attempt, 0..3
fail_count  output  2  consecutive failed attempts
state  output  2  IDLE=0, ENTRY=1, UNLOCKED=2, LOCKOUT=3

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, synchronizers/edge regs 0, timer 0, mismatch flag 0.
- Input path: per bit, 2-FF synchronizer, then a delay reg. ev[j] = sync[j] & ~dly[j], one clk_in cycle wide.
- Latency: btn rises before edge E1; ev is valid after E3; state and outputs update at E4. A held btn produces exactly one event.
- Press: a cycle with ev != 0. Exactly one bit set gives digit = index of that bit. Two or more bits set is an invalid press: it is consumed as one digit and always counts as a mismatch.
- Single timer (width ceil(log2(max cycle param))+1). Cleared on every state entry and on every accepted press in ENTRY.
- IDLE: press → ENTRY. The press is digit 0 (compared, mismatch flag set/cleared), digits_entered=1.
- ENTRY: each press compares with digit[digits_entered] and ORs into the mismatch flag.
  - Press 2 and press 3 increment digits_entered.
  - The 4th press evaluates. All match → UNLOCKED, fail_count=0. Otherwise fail_count+1; if that equals MAX_FAIL → LOCKOUT, else → IDLE.
  - digits_entered returns to 0 on exit.
  - Timer reaching TIMEOUT_CYCLES-1 with no press → IDLE, digits_entered=0, fail_count unchanged (abandon ≠ failure).
  - A press in the same cycle as timeout wins: timer resets, no abandon.
- UNLOCKED: unlocked=1. After UNLOCK_CYCLES cycles → IDLE. Any press → IDLE immediately (relock); that press is discarded, not the start of a new attempt.
- LOCKOUT: alarm=1, all presses ignored. After LOCKOUT_CYCLES cycles → IDLE, fail_count=0.
- fail_count saturates at MAX_FAIL; it is cleared only by success, lockout expiry, or reset.
- Reset mid-operation: immediate return to the reset state. Synchronizers clear, so a btn held high across reset release yields one event after release.
- Outputs are registered directly from state and counters; no combinational path from btn.

Test Plan (TIMEOUT_CYCLES=20, UNLOCK_CYCLES=10, LOCKOUT_CYCLES=30, default CODE/MAX_FAIL):
- Correct code: pulse btn[3],[2],[1],[0], each held 8 cycles with 8-cycle gaps → state 1 after the first press; digits_entered 1,2,3; 4 cycles after the 4th rise, unlocked=1 for exactly 10 cycles, then state=0, fail_count=0.
- Wrong digit: sequence 3,2,0,0 → after the 4th press state=0, fail_count=1, unlocked never asserts. Repeat twice more → alarm=1, state=3 for 30 cycles, then fail_count=0, state=0.
- Lockout ignore and recovery: presses during LOCKOUT → no change to digits_entered. After expiry, a correct code unlocks.
- Timeout: press 3, then wait 25 cycles → state returns to 0 at cycle 20 after the event, digits_entered=0, fail_count unchanged. A press at exactly the timeout cycle keeps state=1.
- Invalid/simultaneous press: btn=4'b1100 as the first digit, then 2,1,0 → counted as failure, fail_count=1. btn held 100 cycles → one event only.
- Relock and reset: press during UNLOCKED → state=0 next cycle, unlocked=0, digits_entered=0. Assert rst mid-ENTRY → all outputs 0 asynchronously.
